// File: rtl/olivia_trace_pkg.sv
// Shared definitions for the Olivia retire trace buffer.
// Holds the FSM state encoding, bus widths, the packed trace record
// and the LEGv8 opcode constants used to build trigger matches.
package olivia_trace_pkg;

    localparam int unsigned PC_W    = 64;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned TS_W    = 16;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned OPC_W   = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic [TS_W-1:0]    ts;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               wr_en;
        logic [REG_W-1:0]   rd;
        logic [DATA_W-1:0]  wdata;
    } trace_rec_t;

    localparam logic [OPC_W-1:0] OPC_ADD  = 11'b10001011000;
    localparam logic [OPC_W-1:0] OPC_SUB  = 11'b11001011000;
    localparam logic [OPC_W-1:0] OPC_AND  = 11'b10001010000;
    localparam logic [OPC_W-1:0] OPC_ORR  = 11'b10101010000;
    localparam logic [OPC_W-1:0] OPC_LDUR = 11'b11111000010;
    localparam logic [OPC_W-1:0] OPC_STUR = 11'b11111000000;
    localparam logic [OPC_W-1:0] OPC_CBZ  = 11'b10110100000;
    localparam logic [OPC_W-1:0] OPC_B    = 11'b00010100000;

endpackage

// File: rtl/retire_trace_buffer_if.sv
// Retire tap and readout bus of the trace buffer.
//   master : datapath/consumer side, drives ret_* and rd_ready
//   slave  : trace buffer side, drives rd_valid and the rd_* record
interface retire_trace_buffer_if;
    import olivia_trace_pkg::*;

    logic               ret_valid;
    logic [PC_W-1:0]    ret_pc;
    logic [INSTR_W-1:0] ret_instr;
    logic               ret_wr_en;
    logic [REG_W-1:0]   ret_rd;
    logic [DATA_W-1:0]  ret_wdata;

    logic               rd_ready;
    logic               rd_valid;
    logic [TS_W-1:0]    rd_ts;
    logic [PC_W-1:0]    rd_pc;
    logic [INSTR_W-1:0] rd_instr;
    logic               rd_wr_en;
    logic [REG_W-1:0]   rd_rd;
    logic [DATA_W-1:0]  rd_wdata;

    modport master (
        output ret_valid, ret_pc, ret_instr, ret_wr_en, ret_rd, ret_wdata,
        output rd_ready,
        input  rd_valid, rd_ts, rd_pc, rd_instr, rd_wr_en, rd_rd, rd_wdata
    );

    modport slave (
        input  ret_valid, ret_pc, ret_instr, ret_wr_en, ret_rd, ret_wdata,
        input  rd_ready,
        output rd_valid, rd_ts, rd_pc, rd_instr, rd_wr_en, rd_rd, rd_wdata
    );

endinterface

// File: rtl/trace_ram.sv
// DEPTH-entry trace record storage.
//   clk          : write clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata  : asynchronous read port
module trace_ram
    import olivia_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  trace_rec_t    wdata,
    input  logic [AW-1:0] raddr,
    output trace_rec_t    rdata
);

    trace_rec_t mem [DEPTH];

    // No reset: contents are only meaningful once written by a capture.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement trace buffer: records one entry per retired instruction into
// a circular buffer, freezes a window around an opcode trigger and plays
// the window back oldest-first.
//   clk, rst              : clock, synchronous active-high reset
//   bus (slave)           : retire tap in, valid/ready record readout out
//   arm, stop             : capture start / forced freeze pulses
//   trig_mask, trig_match : opcode trigger on instr[31:21]
//   state, count          : FSM state and number of valid entries
//   wrapped, triggered    : overwrite seen / trigger fired in this capture
module retire_trace_buffer
    import olivia_trace_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    retire_trace_buffer_if.slave     bus,
    input  logic                     arm,
    input  logic                     stop,
    input  logic [OPC_W-1:0]         trig_mask,
    input  logic [OPC_W-1:0]         trig_match,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wrapped,
    output logic                     triggered
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    trace_state_e    state_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   post_cnt_q;
    logic [TS_W-1:0] ts_q;
    logic            wrapped_q;
    logic            triggered_q;

    logic            capture_c;
    logic            trig_hit_c;
    logic            rd_fire_c;
    logic [AW-1:0]   rd_ptr_c;
    trace_rec_t      wr_rec;
    trace_rec_t      rd_rec;

    assign capture_c  = bus.ret_valid && ((state_q == ST_ARMED) || (state_q == ST_POST));
    assign trig_hit_c = (state_q == ST_ARMED) && bus.ret_valid
                        && ((bus.ret_instr[31:21] & trig_mask) == trig_match);

    // Oldest entry; a full buffer (count==DEPTH) truncates to wr_ptr itself.
    assign rd_ptr_c  = wr_ptr_q - count_q[AW-1:0];
    assign rd_fire_c = bus.rd_valid && bus.rd_ready;

    always_comb begin
        wr_rec       = '0;
        wr_rec.ts    = ts_q;
        wr_rec.pc    = bus.ret_pc;
        wr_rec.instr = bus.ret_instr;
        wr_rec.wr_en = bus.ret_wr_en;
        wr_rec.rd    = bus.ret_rd;
        wr_rec.wdata = bus.ret_wdata;
    end

    trace_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (capture_c),
        .waddr (wr_ptr_q),
        .wdata (wr_rec),
        .raddr (rd_ptr_c),
        .rdata (rd_rec)
    );

    // Capture FSM, pointers, counters and free-running timestamp.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            post_cnt_q  <= '0;
            ts_q        <= '0;
            wrapped_q   <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            ts_q <= ts_q + TS_W'(1);

            if (capture_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                if (count_q == CW'(DEPTH)) begin
                    wrapped_q <= 1'b1;
                end else begin
                    count_q <= count_q + CW'(1);
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_q     <= ST_ARMED;
                        count_q     <= '0;
                        wrapped_q   <= 1'b0;
                        triggered_q <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (trig_hit_c) begin
                        triggered_q <= 1'b1;
                        // A concurrent stop overrides the post-trigger window.
                        if (stop || (POST_TRIG == 0)) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q    <= ST_POST;
                            post_cnt_q <= CW'(POST_TRIG);
                        end
                    end else if (stop) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_POST: begin
                    if (capture_c) begin
                        post_cnt_q <= post_cnt_q - CW'(1);
                    end
                    if (stop || (capture_c && (post_cnt_q == CW'(1)))) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (arm) begin
                        state_q     <= ST_ARMED;
                        count_q     <= '0;
                        wrapped_q   <= 1'b0;
                        triggered_q <= 1'b0;
                    end else if (rd_fire_c) begin
                        count_q <= count_q - CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Readout presents the oldest record combinationally from the RAM.
    assign bus.rd_valid = (state_q == ST_DONE) && (count_q != '0);
    assign bus.rd_ts    = rd_rec.ts;
    assign bus.rd_pc    = rd_rec.pc;
    assign bus.rd_instr = rd_rec.instr;
    assign bus.rd_wr_en = rd_rec.wr_en;
    assign bus.rd_rd    = rd_rec.rd;
    assign bus.rd_wdata = rd_rec.wdata;

    assign state     = state_q;
    assign count     = count_q;
    assign wrapped   = wrapped_q;
    assign triggered = triggered_q;

endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
- Synthesisable on-chip trace buffer for the Olivia LEGv8 core. It captures one record per retired instruction: timestamp, PC, instruction word, and writeback register/value.
- It stores records in a DEPTH-entry circular buffer and freezes a window around an opcode-match trigger.
- Contents are read out oldest-first over a valid/ready port.
- It replaces ad-hoc simulation printing with hardware-visible retirement history. It sits beside the datapath and taps its retire signals.

Parameters:
- DEPTH, 16: number of trace entries; power of two, at least 2.
- POST_TRIG, 4: records captured after the trigger record; must satisfy 0 <= POST_TRIG < DEPTH.
- PC_W, 64: PC width.
- DATA_W, 64: writeback data width.
- TS_W, 16: timestamp width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- ret_valid  in  1  an instruction retires this cycle.
- ret_pc  in  PC_W  PC of the retiring instruction.
- ret_instr  in  32  retiring instruction word.
- ret_wr_en  in  1  retiring instruction writes a register.
- ret_rd  in  5  destination register.
- ret_wdata  in  DATA_W  writeback value.
- arm  in  1  single-cycle pulse that starts a capture.
- stop  in  1  single-cycle pulse that forces a freeze.
- trig_mask  in  11  mask applied to instr[31:21].
- trig_match  in  11  value compared against the masked opcode.
- rd_ready  in  1  consumer accepts the current record.
- rd_valid  out  1  a record is presented.
- rd_ts  out  TS_W  record timestamp.
- rd_pc  out  PC_W  record PC.
- rd_instr  out  32  record instruction word.
- rd_wr_en  out  1  record writeback enable.
- rd_rd  out  5  record destination register.
- rd_wdata  out  DATA_W  record writeback value.
- state  out  2  current state: IDLE=0, ARMED=1, POST=2, DONE=3.
- count  out  $clog2(DEPTH)+1  number of valid entries.
- wrapped  out  1  entries were overwritten since arm.
- triggered  out  1  the trigger fired in this capture.

Behaviour:
- Reset: state=IDLE; wr_ptr=0, count=0, post_cnt=0, ts=0; wrapped=0, triggered=0; rd_valid=0. Memory contents are don't-care.
- ts increments every cycle, including during reset release, and wraps modulo 2^TS_W without saturating.
- A capture event is ret_valid in ARMED or POST. It writes {ts, ret_pc, ret_instr, ret_wr_en, ret_rd, ret_wdata} at wr_ptr and advances wr_ptr modulo DEPTH.
- count saturates at DEPTH. A write while count==DEPTH overwrites the oldest entry and sets wrapped.
- Trigger condition: ARMED && ret_valid && ((ret_instr[31:21] & trig_mask) == trig_match). The trigger record itself is captured and triggered is set.
- IDLE:
  - arm goes to ARMED and clears count, wrapped and triggered.
  - wr_ptr is not reset by arm; oldest = wr_ptr - count.
- ARMED:
  - On trigger with POST_TRIG==0, go to DONE.
  - On trigger with POST_TRIG>0, go to POST with post_cnt=POST_TRIG.
  - stop goes to DONE; triggered stays 0.
- POST:
  - Each capture event decrements post_cnt.
  - The capture that takes post_cnt to 0 goes to DONE in the same cycle.
  - stop goes to DONE immediately; any record on that cycle is still captured.
- DONE:
  - Capture is frozen.
  - rd_valid = (count != 0). The record at rd_ptr = wr_ptr - count (mod DEPTH) is driven combinationally onto rd_*.
  - rd_valid && rd_ready decrements count; record order is oldest first.
  - When count reaches 0, rd_valid drops; state stays DONE.
  - arm in DONE, including mid-readout, discards the remaining records and goes to ARMED with count cleared.
- Simultaneous events:
  - arm is ignored in ARMED and POST.
  - stop is ignored in IDLE and DONE.
  - arm and stop together in IDLE: arm wins.
  - stop and trigger on the same cycle in ARMED: capture occurs, triggered=1, state goes to DONE regardless of POST_TRIG.
- rd_* outputs are don't-care when rd_valid=0.
- rst mid-capture or mid-readout returns all reset values on the next edge.

Decomposition:
- Shared package olivia_trace_pkg holds:
  - the state encoding constants;
  - the packed trace-record typedef {ts, pc, instr, wr_en, rd, wdata};
  - the opcode constants (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000, CBZ 10110100000, B 00010100000).
- One sub-module, trace_ram: DEPTH x record width, one synchronous write port, one asynchronous read port.
- FSM, pointers and counters live in retire_trace_buffer.

Test Plan:
1. Reset then idle: hold rst 2 cycles, drive ret_valid=1 for 5 cycles without arm -> state=0, count=0, rd_valid=0, triggered=0.
2. Basic trigger, DEPTH=16, POST_TRIG=4: arm with mask=7FF, match=CBZ (10110100000); retire 3 ADDs, 1 CBZ, then 6 more.
   - Expect DONE after the 4th post-trigger record, count=8, wrapped=0, triggered=1.
   - Readout yields PCs 0,4,8,12,16,20,24,28 in order, then rd_valid=0.
3. Wrap: arm with a never-matching trigger (mask=7FF, match=0), retire 20 instructions at PC=4*i, then pulse stop.
   - Expect count=16, wrapped=1; first read PC=16, last read PC=76.
4. Readout backpressure: in DONE with count=8, toggle rd_ready every other cycle -> exactly 8 handshakes, each record stable while rd_ready=0.
5. Simultaneous stop and trigger: in ARMED, a matching instruction and stop on the same cycle -> record captured, triggered=1, state=DONE next cycle.
6. Re-arm mid-readout: in DONE after 3 of 8 reads, pulse arm -> state=ARMED, count=0, rd_valid=0. Pulse rst during POST -> all outputs at reset values next cycle.
